inst_encoder: RTL and testbench

- Inverse of the core's instruction decoder. Accepts field-level instruction descriptors (kind, alu_op, rs1, rs2, rd, imm) over a valid/ready handshake.
- Encodes each valid descriptor into a 32-bit RV32 word for the supported subset (R-ALU, I-ALU, branch, ECALL).
- Writes encoded words sequentially into instruction memory through a write/ack port.
- Used by the boot loader and test harness to build programs in IMEM. Illegal descriptors are rejected and counted, never written.

---
 rtl/inst_encoder_pkg.sv | 23 ++
 rtl/inst_pack.sv | 71 +++++++
 rtl/inst_encoder.sv | 115 +++++++++++
 tb/tb_inst_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder slice.
// Holds the RV32 major opcodes used by the supported subset (shared with the
// decoder), the descriptor kind codes and the encoder FSM state type.
package inst_encoder_pkg;

  // RV32 major opcodes for the supported instruction classes
  localparam logic [6:0] OPCODE_R = 7'b0110011;
  localparam logic [6:0] OPCODE_I = 7'b0010011;
  localparam logic [6:0] OPCODE_B = 7'b1100011;
  localparam logic [6:0] OPCODE_E = 7'b1110011;

  // Descriptor kind codes carried on req_kind
  localparam logic [1:0] KIND_R = 2'd0;
  localparam logic [1:0] KIND_I = 2'd1;
  localparam logic [1:0] KIND_B = 2'd2;
  localparam logic [1:0] KIND_E = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } enc_state_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational field-to-word packer for the RV32 subset (R-ALU, I-ALU,
// branch, ECALL). Produces the encoded word and a flag telling whether the
// descriptor is legal.
// Ports:
//   kind   in  2   descriptor kind (KIND_*)
//   alu_op in  4   [2:0]=funct3, [3]=inst[30]
//   rs1    in  5   source register 1
//   rs2    in  5   source register 2
//   rd     in  5   destination register
//   imm    in  32  signed immediate / branch byte offset
//   word   out 32  encoded instruction
//   valid  out 1   descriptor is encodable
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [3:0]  alu_op,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        valid
);

  logic [2:0] funct3;
  logic       alt;
  logic       is_shift;

  assign funct3   = alu_op[2:0];
  assign alt      = alu_op[3];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Pack fields by instruction kind and qualify the descriptor
  always_comb begin
    word  = 32'h0000_0000;
    valid = 1'b0;
    case (kind)
      KIND_R: begin
        word  = {1'b0, alt, 5'b00000, rs2, rs1, funct3, rd, OPCODE_R};
        // inst[30] only distinguishes SUB and SRA
        valid = !alt || (funct3 == 3'b000) || (funct3 == 3'b101);
      end
      KIND_I: begin
        if (is_shift) begin
          // shamt lives in imm[4:0]; inst[30] selects SRAI
          word  = {1'b0, alt, 5'b00000, imm[4:0], rs1, funct3, rd, OPCODE_I};
          valid = (imm[31:5] == 27'd0) && !(alt && (funct3 == 3'b001));
        end else begin
          word  = {imm[11:0], rs1, funct3, rd, OPCODE_I};
          valid = (imm[31:11] == {21{imm[11]}}) && !alt;
        end
      end
      KIND_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPCODE_B};
        // 13-bit signed even offset; funct3 010/011 are not branches
        valid = !imm[0] && (imm[31:12] == {20{imm[12]}}) &&
                (funct3 != 3'b010) && (funct3 != 3'b011) && !alt;
      end
      KIND_E: begin
        word  = {25'd0, OPCODE_E};
        valid = 1'b1;
      end
      default: begin
        word  = 32'h0000_0000;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts field-level descriptors over valid/ready,
// encodes legal ones and writes them sequentially into instruction memory
// through a write/ack port. Illegal descriptors are rejected and counted.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   restart             rewind write pointer and clear full (IDLE only)
//   req_valid/req_ready descriptor handshake
//   req_kind, req_alu_op, req_rs1, req_rs2, req_rd, req_imm  descriptor fields
//   mem_we, mem_addr, mem_wdata, mem_ack  memory write port
//   err                 one-cycle pulse on rejected descriptor
//   err_count           saturating count of rejected descriptors
//   word_count          words written since reset/restart
//   full                DEPTH words written
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          ERR_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     restart,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_kind,
  input  logic [3:0]               req_alu_op,
  input  logic [4:0]               req_rs1,
  input  logic [4:0]               req_rs2,
  input  logic [4:0]               req_rd,
  input  logic [31:0]              req_imm,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ack,
  output logic                     err,
  output logic [ERR_W-1:0]         err_count,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     full
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    LAST_WORD = CW'(DEPTH - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  enc_state_t  state;
  logic [31:0] pack_word;
  logic        pack_valid;

  inst_pack u_pack (
    .kind   (req_kind),
    .alu_op (req_alu_op),
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .rd     (req_rd),
    .imm    (req_imm),
    .word   (pack_word),
    .valid  (pack_valid)
  );

  // restart takes priority over a new descriptor in IDLE
  assign req_ready = (state == ST_IDLE) && !full && !restart;

  // FSM, write port registers, counters and error reporting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'h0000_0000;
      err        <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      full       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (restart) begin
            mem_addr   <= BASE_ADDR;
            word_count <= '0;
            full       <= 1'b0;
          end else if (req_valid && !full) begin
            if (pack_valid) begin
              mem_wdata <= pack_word;
              mem_we    <= 1'b1;
              state     <= ST_WRITE;
            end else begin
              err <= 1'b1;
              if (err_count != '1) begin
                err_count <= err_count + ERR_ONE;
              end
            end
          end
        end
        ST_WRITE: begin
          // address and data stay frozen until the memory accepts
          if (mem_ack) begin
            mem_we     <= 1'b0;
            mem_addr   <= mem_addr + 32'd4;
            word_count <= word_count + CNT_ONE;
            full       <= (word_count == LAST_WORD);
            state      <= ST_IDLE;
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;
  localparam int          ERR_W = 8;

  logic        clk = 1'b0;
  logic        rst_n, restart, req_valid, req_ready, mem_ack;
  logic [1:0]  req_kind;
  logic [3:0]  req_alu_op;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic [31:0] req_imm;
  logic        mem_we, err, full;
  logic [31:0] mem_addr, mem_wdata;
  logic [ERR_W-1:0] err_count;
  logic [2:0]  word_count;
  logic [31:0] ref_word;
  logic        ref_ok;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [31:0] m_addr;
  int          m_count;
  logic        m_full;
  int          m_err;

  always #5 clk = ~clk;

  inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_alu_op(req_alu_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .err(err), .err_count(err_count), .word_count(word_count), .full(full)
  );

  // standalone packer, cross-checked against the arithmetic model
  inst_pack ref_pack (
    .kind(req_kind), .alu_op(req_alu_op), .rs1(req_rs1), .rs2(req_rs2),
    .rd(req_rd), .imm(req_imm), .word(ref_word), .valid(ref_ok)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Encoding rules computed with plain integer arithmetic
  function automatic void model_enc(input logic [1:0] k, input logic [3:0] op,
                                    input logic [4:0] r1, input logic [4:0] r2,
                                    input logic [4:0] d, input logic [31:0] im,
                                    output logic [31:0] w, output logic ok);
    int s;
    logic [31:0] f3, alt, u, base;
    s    = $signed(im);
    f3   = 32'(op % 4'd8);
    alt  = 32'(op / 4'd8);
    base = 32'(r1) * 32'd32768 + f3 * 32'd4096;
    w = 32'd0;
    ok = 1'b1;
    case (k)
      2'd0: begin
        ok = (alt == 32'd0) || (f3 == 32'd0) || (f3 == 32'd5);
        w  = alt * 32'd1073741824 + 32'(r2) * 32'd1048576 + base + 32'(d) * 32'd128 + 32'd51;
      end
      2'd1: begin
        if (f3 == 32'd1 || f3 == 32'd5) begin
          ok = (im < 32'd32) && !(alt == 32'd1 && f3 == 32'd1);
          w  = alt * 32'd1073741824 + (im % 32'd32) * 32'd1048576 + base + 32'(d) * 32'd128 + 32'd19;
        end else begin
          ok = (s >= -2048) && (s <= 2047) && (alt == 32'd0);
          w  = (im % 32'd4096) * 32'd1048576 + base + 32'(d) * 32'd128 + 32'd19;
        end
      end
      2'd2: begin
        ok = (s % 2 == 0) && (s >= -4096) && (s <= 4094) && (f3 != 32'd2) && (f3 != 32'd3) && (alt == 32'd0);
        u  = im % 32'd8192;
        w  = ((u / 32'd4096) % 32'd2) * 32'h8000_0000 + ((u / 32'd32) % 32'd64) * 32'd33554432
           + 32'(r2) * 32'd1048576 + base + ((u / 32'd2) % 32'd16) * 32'd256
           + ((u / 32'd2048) % 32'd2) * 32'd128 + 32'd99;
      end
      default: begin
        ok = 1'b1;
        w  = 32'd115;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_addr = BASE; m_count = 0; m_full = 1'b0; m_err = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_we"}, mem_we, 32'd0);
    check_eq({tag, "_addr"}, mem_addr, BASE);
    check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_err"}, err, 32'd0);
    check_eq({tag, "_errcnt"}, err_count, 32'd0);
    check_eq({tag, "_wcnt"}, word_count, 32'd0);
    check_eq({tag, "_full"}, full, 32'd0);
  endtask

  // One descriptor through the handshake; all entry/exit at negedge
  task automatic send(input logic [1:0] k, input logic [3:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] d, input logic [31:0] im,
                      input int ack_wait, input logic tp_en, input logic [31:0] tp_word);
    logic [31:0] w;
    logic ok;
    model_enc(k, op, r1, r2, d, im, w, ok);
    req_kind = k; req_alu_op = op; req_rs1 = r1; req_rs2 = r2; req_rd = d; req_imm = im;
    req_valid = 1'b1;
    #1;
    check_eq("ready_idle", req_ready, 32'd1);
    check_eq("pack_valid", ref_ok, ok);
    if (ok) check_eq("pack_word", ref_word, w);
    @(negedge clk);
    req_valid = 1'b0;
    if (ok) begin
      check_eq("we_set", mem_we, 32'd1);
      check_eq("addr", mem_addr, m_addr);
      check_eq("wdata", mem_wdata, w);
      if (tp_en) check_eq("wdata_plan", mem_wdata, tp_word);
      check_eq("err_quiet", err, 32'd0);
      check_eq("ready_busy", req_ready, 32'd0);
      for (int i = 0; i < ack_wait; i++) begin
        if (i == 1) restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_eq("hold_we", mem_we, 32'd1);
        check_eq("hold_addr", mem_addr, m_addr);
        check_eq("hold_wdata", mem_wdata, w);
        check_eq("hold_ready", req_ready, 32'd0);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      m_addr  = m_addr + 32'd4;
      m_count = m_count + 1;
      if (m_count == DEPTH) m_full = 1'b1;
      check_eq("we_drop", mem_we, 32'd0);
      check_eq("addr_next", mem_addr, m_addr);
      check_eq("wcnt", word_count, 32'(m_count));
      check_eq("full", full, 32'(m_full));
      check_eq("ready_after", req_ready, 32'(!m_full));
    end else begin
      if (m_err < 255) m_err = m_err + 1;
      check_eq("err_pulse", err, 32'd1);
      check_eq("err_nowrite", mem_we, 32'd0);
      check_eq("err_count", err_count, 32'(m_err));
      check_eq("err_addr", mem_addr, m_addr);
      @(negedge clk);
      check_eq("err_clear", err, 32'd0);
    end
  endtask

  // Request while full must stall with no write
  task automatic stall_check();
    req_kind = KIND_E; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("full_ready", req_ready, 32'd0);
      @(negedge clk);
      check_eq("full_nowrite", mem_we, 32'd0);
      check_eq("full_wcnt", word_count, 32'(m_count));
    end
    req_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1; req_kind = KIND_E; req_valid = 1'b1;
    #1;
    check_eq("restart_ready", req_ready, 32'd0);
    @(negedge clk);
    restart = 1'b0; req_valid = 1'b0;
    m_addr = BASE; m_count = 0; m_full = 1'b0;
    check_eq("restart_we", mem_we, 32'd0);
    check_eq("restart_addr", mem_addr, BASE);
    check_eq("restart_wcnt", word_count, 32'd0);
    check_eq("restart_full", full, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] im;
    rst_n = 1'b0; restart = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
    req_kind = 2'd0; req_alu_op = 4'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd0; req_imm = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // directed plan
    send(KIND_R, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0, 0, 1'b1, 32'h002081B3);
    send(KIND_R, 4'b1000, 5'd1, 5'd2, 5'd3, 32'd0, 1, 1'b1, 32'h402081B3);
    send(KIND_I, 4'b0000, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFF00293);
    send(KIND_I, 4'b1101, 5'd1, 5'd0, 5'd1, 32'd3, 5, 1'b1, 32'h4030D093);
    stall_check();
    do_restart();
    send(KIND_B, 4'b0000, 5'd1, 5'd2, 5'd0, 32'd8, 0, 1'b1, 32'h00208463);
    send(KIND_B, 4'b0000, 5'd1, 5'd2, 5'd0, 32'd7, 0, 1'b0, 32'd0);
    send(KIND_B, 4'b0000, 5'd1, 5'd2, 5'd0, 32'd4096, 0, 1'b0, 32'd0);
    check_eq("err_two", err_count, 32'd2);
    send(KIND_E, 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 2, 1'b1, 32'h00000073);
    send(KIND_R, 4'b1001, 5'd1, 5'd2, 5'd3, 32'd0, 0, 1'b0, 32'd0);

    // reset while a write is pending
    req_kind = KIND_R; req_alu_op = 4'd0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("wr_pending", mem_we, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("rst_wr");
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // saturate the error counter
    for (int i = 0; i < 300; i++) send(KIND_R, 4'b1001, 5'd0, 5'd0, 5'd0, 32'd0, 0, 1'b0, 32'd0);
    check_eq("err_sat", err_count, 32'd255);

    // randomized descriptors
    for (int n = 0; n < 250; n++) begin
      if (m_full) begin
        stall_check();
        do_restart();
      end
      if ($urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("idle_ack_addr", mem_addr, m_addr);
        check_eq("idle_ack_wcnt", word_count, 32'(m_count));
      end
      case ($urandom_range(0, 4))
        0: im = 32'($urandom_range(0, 31));
        1: im = 32'(int'($urandom_range(0, 4095)) - 2048);
        2: im = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        3: im = $urandom;
        default: im = 32'($urandom_range(0, 40) * 2 + 1);
      endcase
      send(2'($urandom), 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im,
           int'($urandom_range(0, 3)), 1'b0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
